md_unit: RTL

Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath. It sits directly downstream of the ALU operand-select muxes and takes the same forwarded rs/rt operands the ALU sees. It models MULT/MULTU/DIV/DIVU latency with a busy counter so the hazard unit can stall MFHI/MFLO and new md ops. HI/LO feed the writeback-data select mux.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_busy_ctr.sv | 34 +++
 rtl/md_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, busy-counter width and the HI/LO result payload.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MADDU = 3'd7;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;
  localparam int unsigned MD_CTR_W       = 4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_busy_ctr.sv
// Loadable down-counter: busy stays high for len cycles after a load and
// done_c pulses during the last busy cycle (the edge that ends it).
module md_busy_ctr
  import md_pkg::*;
#(
  parameter int unsigned W = MD_CTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         busy,
  output logic         done_c
);

  logic [W-1:0] count;

  // Remaining-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= '0;
    else if (load)          count <= len;
    else if (count != '0)   count <= count - W'(1);
  end

  // Registered busy flag, cleared on the edge that completes the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        busy <= 1'b0;
    else if (load)    busy <= (len != '0);
    else if (done_c)  busy <= 1'b0;
  end

  assign done_c = (count == W'(1));

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at launch and held in a pending register until the
// busy counter expires, which models the MULT/DIV latency for the hazard unit.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU (ops 6/7).
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  logic [63:0]         prod_s, prod_u;
  logic [31:0]         dvs, abs_a, abs_b, uq, ur, sq, sr, udq, udr;
  md_res_t             res_c, pend;
  logic                res_wr_c, pend_wr;
  logic                long_c, wr_hi_c, wr_lo_c, accept_c, done_c;
  logic [MD_CTR_W-1:0] len_c;

  // Products and quotients; a zero divisor is replaced to keep the divider defined
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    dvs    = (b == 32'd0) ? 32'd1 : b;
    abs_a  = a[31] ? (32'd0 - a) : a;
    abs_b  = dvs[31] ? (32'd0 - dvs) : dvs;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    sq     = (a[31] ^ dvs[31]) ? (32'd0 - uq) : uq;
    sr     = a[31] ? (32'd0 - ur) : ur;
    udq    = a / dvs;
    udr    = a % dvs;
  end

  // Op decode: result payload, latency and direct HI/LO writes
  always_comb begin
    res_c    = '0;
    res_wr_c = 1'b0;
    long_c   = 1'b0;
    len_c    = '0;
    wr_hi_c  = 1'b0;
    wr_lo_c  = 1'b0;
    case (op)
      MD_MULT: begin
        long_c   = 1'b1;
        len_c    = MD_CTR_W'(MULT_CYCLES);
        res_wr_c = 1'b1;
        {res_c.hi, res_c.lo} = prod_s;
      end
      MD_MULTU: begin
        long_c   = 1'b1;
        len_c    = MD_CTR_W'(MULT_CYCLES);
        res_wr_c = 1'b1;
        {res_c.hi, res_c.lo} = prod_u;
      end
      MD_DIV: begin
        long_c   = 1'b1;
        len_c    = MD_CTR_W'(DIV_CYCLES);
        res_wr_c = (b != 32'd0);
        res_c.hi = sr;
        res_c.lo = sq;
      end
      MD_DIVU: begin
        long_c   = 1'b1;
        len_c    = MD_CTR_W'(DIV_CYCLES);
        res_wr_c = (b != 32'd0);
        res_c.hi = udr;
        res_c.lo = udq;
      end
      MD_MTHI: wr_hi_c = 1'b1;
      MD_MTLO: wr_lo_c = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD: begin
        long_c   = 1'b1;
        len_c    = MD_CTR_W'(MULT_CYCLES);
        res_wr_c = 1'b1;
        {res_c.hi, res_c.lo} = {hi, lo} + prod_s;
      end
      MD_MADDU: begin
        long_c   = 1'b1;
        len_c    = MD_CTR_W'(MULT_CYCLES);
        res_wr_c = 1'b1;
        {res_c.hi, res_c.lo} = {hi, lo} + prod_u;
      end
`endif
      default: ;
    endcase
  end

  assign accept_c = start & ~busy;

  md_busy_ctr #(.W(MD_CTR_W)) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_c & long_c),
    .len    (len_c),
    .busy   (busy),
    .done_c (done_c)
  );

  // Pending result captured at launch, committed when the counter expires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (accept_c && long_c) begin
      pend    <= res_c;
      pend_wr <= res_wr_c;
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done_c && pend_wr) begin
      hi <= pend.hi;
      lo <= pend.lo;
    end else if (accept_c) begin
      if (wr_hi_c) hi <= a;
      if (wr_lo_c) lo <= a;
    end
  end

endmodule
